// File: rtl/lsu_master_pkg.sv
// lsu_master_pkg: shared definitions for the load/store initiator.
//   - access-size op encodings (word, half, byte, unsigned half, unsigned byte)
//   - exception codes raised by the LSU (AdEL, AdES, DBE)
//   - FSM state type and an op-legality helper
package lsu_master_pkg;

  localparam logic [2:0] OP_WD  = 3'd0;
  localparam logic [2:0] OP_HF  = 3'd1;
  localparam logic [2:0] OP_BT  = 3'd2;
  localparam logic [2:0] OP_UHF = 3'd3;
  localparam logic [2:0] OP_UBT = 3'd4;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_WD) || (op == OP_HF) || (op == OP_BT) ||
           (op == OP_UHF) || (op == OP_UBT);
  endfunction

endpackage

// File: rtl/lsu_master_lane.sv
// lsu_lane: combinational byte-lane logic for the LSU.
//   op_i        access size
//   addr_lo_i   byte offset within the word
//   wdata_i     right-aligned store data
//   mem_rdata_i raw bus read word
//   be_o        byte enables, bit k = bits 8k+7:8k
//   wdata_o     store data replicated across all lanes
//   rdata_o     selected lane, sign- or zero-extended
//   misalign_o  access does not meet the size's alignment
module lsu_lane
  import lsu_master_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  // Selected lane shifted down to bit 0
  logic [31:0] shifted;
  assign shifted = mem_rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = mem_rdata_i;
    misalign_o = 1'b0;
    case (op_i)
      OP_WD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      OP_HF, OP_UHF: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
        rdata_o    = (op_i == OP_HF) ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'b0, shifted[15:0]};
      end
      OP_BT, OP_UBT: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (op_i == OP_BT) ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'b0, shifted[7:0]};
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: MEM-stage load/store initiator.
//   clk, rst_n             clock, asynchronous active-low reset
//   en, we, op, addr,      access request from the MEM stage
//   wdata, flush
//   stall                  hold the pipeline while the access is in flight
//   rdata, rvalid          extended load result and completion strobe
//   exc, exc_code          exception strobe (AdEL / AdES / DBE)
//   mem_*                  word-addressed, byte-enabled req/ack data bus
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);

  lsu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              kill_q;
  logic [2:0]        op_q;
  logic [1:0]        addr_lo_q;
  logic              mem_req_q, mem_we_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_addr_q, mem_wdata_q;
  logic [31:0]       rdata_q, rdata_prev_q;
  logic              rvalid_q, exc_q;
  logic [4:0]        exc_code_q;

  logic [2:0]  lane_op;
  logic [1:0]  lane_addr_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_misalign;
  logic        idle_req, issue, misal, suppress;

  // In IDLE the lane logic sees the live request; afterwards it sees the
  // captured op/offset so load extraction matches the issued access.
  assign lane_op      = (state_q == ST_IDLE) ? op         : op_q;
  assign lane_addr_lo = (state_q == ST_IDLE) ? addr[1:0]  : addr_lo_q;

  lsu_lane u_lane (
    .op_i        (lane_op),
    .addr_lo_i   (lane_addr_lo),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata),
    .misalign_o  (lane_misalign)
  );

  assign idle_req = (state_q == ST_IDLE) && en && op_legal(op) && !flush;
  assign issue    = idle_req && !lane_misalign;
  assign misal    = idle_req && lane_misalign;
  assign suppress = kill_q || flush;

  assign stall     = rst_n && (issue || (state_q == ST_WAIT));
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign exc       = exc_q;
  assign exc_code  = exc_code_q;
  // A flush arriving in DONE hides the completion and the fresh load data.
  assign rvalid    = rvalid_q && !flush;
  assign rdata     = (rvalid_q && flush) ? rdata_prev_q : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      op_q         <= '0;
      addr_lo_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      rdata_prev_q <= '0;
      rvalid_q     <= 1'b0;
      exc_q        <= 1'b0;
      exc_code_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      exc_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          kill_q <= 1'b0;
          cnt_q  <= '0;
          if (issue) begin
            op_q        <= op;
            addr_lo_q   <= addr[1:0];
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_we_q    <= we;
            mem_be_q    <= lane_be;
            mem_wdata_q <= lane_wdata;
            mem_req_q   <= 1'b1;
            state_q     <= ST_WAIT;
          end else if (misal) begin
            exc_q      <= 1'b1;
            exc_code_q <= we ? EXC_ADES : EXC_ADEL;
          end
        end
        ST_WAIT: begin
          if (flush) kill_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_DONE;
            if (!suppress) begin
              rvalid_q     <= 1'b1;
              rdata_prev_q <= rdata_q;
              if (!mem_we_q) rdata_q <= lane_rdata;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            if (!suppress) begin
              exc_q      <= 1'b1;
              exc_code_q <= EXC_DBE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          // Roll back the load data the flushed instruction wrote
          if (rvalid_q && flush) rdata_q <= rdata_prev_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
